// File: rtl/led_flash_multi_if.sv
// Bundles the per-channel LED flasher inputs and LED outputs.
// The master drives activity, mode and period; the slave drives LED.
interface led_flash_multi_if #(
  parameter int NCH = 4,
  parameter int CW  = 24
);
  logic [NCH-1:0]   signal;
  logic [2*NCH-1:0] mode;
  logic [CW-1:0]    period;
  logic [NCH-1:0]   LED;

  modport master (output signal, mode, period, input LED);
  modport slave  (input signal, mode, period, output LED);
endinterface

// File: rtl/led_flash_multi.sv
// Multi-channel LED flasher: each channel stretches, blinks, pulses or forces its
// LED from a shared period. Channels are fully independent lane instances.
module led_flash_lane #(
  parameter int CW = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sig_i,
  input  logic [1:0]    mode_i,
  input  logic [CW-1:0] period_i,
  output logic          lit_o
);
  typedef enum logic [1:0] {
    MODE_STRETCH = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_FORCE   = 2'b11
  } mode_e;

  logic          lit_q, lit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sig_prev_q, sig_prev_d;
  mode_e         mode_prev_q, mode_prev_d;
  mode_e         mode_cur;
  logic          expired;

  assign mode_cur = mode_e'(mode_i);
  // ">=" rather than "==" so a shrinking period ends the phase instead of wrapping
  assign expired  = (cnt_q >= period_i);

  always_comb begin
    lit_d       = lit_q;
    cnt_d       = cnt_q;
    sig_prev_d  = sig_i;
    mode_prev_d = mode_cur;
    if (mode_cur != mode_prev_q) begin
      // mode switch restarts the channel and ignores signal on this edge
      cnt_d = '0;
      lit_d = (mode_cur == MODE_FORCE);
    end else begin
      unique case (mode_cur)
        MODE_STRETCH: begin
          if (sig_i) begin
            cnt_d = '0;
            lit_d = 1'b1;
          end else if (expired) begin
            lit_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_BLINK: begin
          if (!sig_i) begin
            // preload so the next high edge lights immediately
            lit_d = 1'b0;
            cnt_d = period_i;
          end else if (expired) begin
            cnt_d = '0;
            lit_d = ~lit_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_PULSE: begin
          if (sig_i && !sig_prev_q) begin
            lit_d = 1'b1;
            cnt_d = '0;
          end else if (lit_q) begin
            if (expired) lit_d = 1'b0;
            else         cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_FORCE: begin
          lit_d = 1'b1;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lit_q       <= 1'b0;
      cnt_q       <= '0;
      sig_prev_q  <= 1'b0;
      mode_prev_q <= MODE_STRETCH;
    end else begin
      lit_q       <= lit_d;
      cnt_q       <= cnt_d;
      sig_prev_q  <= sig_prev_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign lit_o = lit_q;
endmodule

module led_flash_multi #(
  parameter int NCH        = 4,
  parameter int CW         = 24,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  led_flash_multi_if.slave bus
);
  logic [NCH-1:0] lit;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    led_flash_lane #(.CW(CW)) u_lane (
      .clock    (clock),
      .reset    (reset),
      .sig_i    (bus.signal[i]),
      .mode_i   (bus.mode[2*i +: 2]),
      .period_i (bus.period),
      .lit_o    (lit[i])
    );
  end

  // lit is already a flop, so LED needs no extra output stage
  assign bus.LED = lit ^ {NCH{ACTIVE_LOW}};
endmodule

// File: tb/tb_led_flash_multi.sv
// Directed bench for led_flash_multi (NCH=4, ACTIVE_LOW=1): per-cycle model compare
// plus literal LED expectations at key points of each scenario.
module tb_led_flash_multi;
  localparam int NCH = 4;
  localparam int CW  = 24;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  led_flash_multi_if #(.NCH(NCH), .CW(CW)) bus ();

  led_flash_multi #(.NCH(NCH), .CW(CW), .ACTIVE_LOW(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural reference: one lit bit, one counter, previous signal and mode per channel
  bit [NCH-1:0] m_lit;
  int           m_cnt   [NCH];
  bit [NCH-1:0] m_sig_p;
  int           m_mode_p[NCH];

  always @(posedge clock) begin
    bit [NCH-1:0] nl;
    int           nc [NCH];
    int           md, per;
    bit           s;
    per = int'(bus.period);
    for (int c = 0; c < NCH; c++) begin
      md    = int'(bus.mode[2*c +: 2]);
      s     = bus.signal[c];
      nl[c] = m_lit[c];
      nc[c] = m_cnt[c];
      if (reset) begin
        nl[c] = 1'b0; nc[c] = 0;
      end else if (md != m_mode_p[c]) begin
        nl[c] = (md == 3); nc[c] = 0;
      end else if (md == 0) begin
        if (s)                   begin nl[c] = 1'b1; nc[c] = 0; end
        else if (m_cnt[c] >= per) nl[c] = 1'b0;
        else                      nc[c] = m_cnt[c] + 1;
      end else if (md == 1) begin
        if (!s)                   begin nl[c] = 1'b0; nc[c] = per; end
        else if (m_cnt[c] >= per) begin nl[c] = !m_lit[c]; nc[c] = 0; end
        else                      nc[c] = m_cnt[c] + 1;
      end else if (md == 2) begin
        if (s && !m_sig_p[c])     begin nl[c] = 1'b1; nc[c] = 0; end
        else if (m_lit[c]) begin
          if (m_cnt[c] >= per) nl[c] = 1'b0;
          else                 nc[c] = m_cnt[c] + 1;
        end
      end else begin
        nl[c] = 1'b1; nc[c] = 0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c]    <= nc[c];
      m_mode_p[c] <= reset ? 0 : int'(bus.mode[2*c +: 2]);
    end
    m_lit   <= nl;
    m_sig_p <= reset ? '0 : bus.signal;
  end

  // every cycle: LED must be the inverted model lit vector
  always @(negedge clock) begin
    checks++;
    if (bus.LED !== ~m_lit) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t LED=%b expected=%b", $time, bus.LED, ~m_lit);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // exp_lit is the internal lit state; with ACTIVE_LOW the pin is its inverse
  task automatic chk_lit(input string nm, input int ch, input bit exp_lit);
    checks++;
    if (bus.LED[ch] !== !exp_lit) begin
      failures++;
      $display("FAIL %s LED[%0d]=%b expected=%b", nm, ch, bus.LED[ch], !exp_lit);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [NCH-1:0] exp_led);
    checks++;
    if (bus.LED !== exp_led) begin
      failures++;
      $display("FAIL %s LED=%b expected=%b", nm, bus.LED, exp_led);
    end
  endtask

  initial begin
    m_lit = '0; m_sig_p = '0;
    for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_mode_p[c] = 0; end
    reset      = 1'b1;
    bus.signal = '0;
    bus.period = '0;
    bus.mode   = 8'b11_10_01_00;   // ch3 FORCE, ch2 PULSE, ch1 BLINK, ch0 STRETCH

    // reset overrides FORCE; then ch3 lights on the first edge after release
    tick(3);
    chk_vec("reset_all_dark", 4'b1111);
    reset = 1'b0;
    tick(1);
    chk_vec("release_force_lit", 4'b0111);
    tick(2);
    chk_vec("idle_after_release", 4'b0111);

    // STRETCH, period 5: 3 high then low; dark on the 6th low edge
    bus.period = 24'd5;
    bus.signal[0] = 1'b1;
    tick(1);  chk_lit("stretch_first_high", 0, 1'b1);
    tick(2);
    bus.signal[0] = 1'b0;
    tick(5);  chk_lit("stretch_5th_low", 0, 1'b1);
    tick(1);  chk_lit("stretch_6th_low", 0, 1'b0);

    // BLINK, period 3: 4-cycle phases, lit on the first high edge
    bus.period = 24'd3;
    bus.signal[1] = 1'b1;
    tick(1);  chk_lit("blink_edge1", 1, 1'b1);
    tick(3);  chk_lit("blink_edge4", 1, 1'b1);
    tick(1);  chk_lit("blink_edge5", 1, 1'b0);
    tick(4);  chk_lit("blink_edge9", 1, 1'b1);
    tick(11); chk_lit("blink_edge20", 1, 1'b1);
    bus.signal[1] = 1'b0;
    tick(1);  chk_lit("blink_low", 1, 1'b0);

    // PULSE, period 10: retrigger 6 cycles later gives 17 lit cycles
    bus.period = 24'd10;
    bus.signal[2] = 1'b1;
    tick(1);  chk_lit("pulse_start", 2, 1'b1);
    bus.signal[2] = 1'b0;
    tick(5);
    bus.signal[2] = 1'b1;
    tick(1);
    bus.signal[2] = 1'b0;
    tick(10); chk_lit("pulse_retrig_last", 2, 1'b1);
    tick(1);  chk_lit("pulse_retrig_end", 2, 1'b0);
    // 30-cycle-wide pulse lights exactly 11 cycles
    bus.signal[2] = 1'b1;
    tick(1);  chk_lit("wide_start", 2, 1'b1);
    tick(10); chk_lit("wide_11th", 2, 1'b1);
    tick(1);  chk_lit("wide_12th", 2, 1'b0);
    tick(18); chk_lit("wide_still_high", 2, 1'b0);
    bus.signal[2] = 1'b0;
    tick(2);

    // STRETCH period 1000, counter at 500, period drops to 100
    bus.period = 24'd1000;
    bus.signal[0] = 1'b1;
    tick(1);
    bus.signal[0] = 1'b0;
    tick(500); chk_lit("long_hold_500", 0, 1'b1);
    bus.period = 24'd100;
    tick(1);   chk_lit("period_shrink", 0, 1'b0);

    // STRETCH -> PULSE while lit with signal high
    bus.period = 24'd10;
    bus.signal[0] = 1'b1;
    tick(1);  chk_lit("pre_switch_lit", 0, 1'b1);
    bus.mode = 8'b11_10_01_10;
    tick(1);  chk_lit("switch_edge", 0, 1'b0);
    tick(3);  chk_lit("switch_high_no_edge", 0, 1'b0);
    bus.signal[0] = 1'b0;
    tick(1);
    bus.signal[0] = 1'b1;
    tick(1);  chk_lit("post_switch_pulse", 0, 1'b1);
    bus.signal[0] = 1'b0;
    tick(10); chk_lit("post_switch_11th", 0, 1'b1);
    tick(1);  chk_lit("post_switch_end", 0, 1'b0);

    // reset mid-pulse leaves nothing lit afterwards
    bus.signal[0] = 1'b1;
    tick(1);  chk_lit("pulse_before_reset", 0, 1'b1);
    bus.signal[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);  chk_vec("mid_pulse_reset", 4'b1111);
    reset = 1'b0;
    tick(1);  chk_vec("after_mid_reset", 4'b0111);
    tick(3);  chk_vec("after_mid_reset_idle", 4'b0111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
